// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store funct3 codes and store FSM state encoding
package store_unit_pkg;

    localparam logic [2:0] INST_SB = 3'b000;
    localparam logic [2:0] INST_SH = 3'b001;
    localparam logic [2:0] INST_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_WR1  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/store_unit_align.sv
// store_unit_align: lane alignment and strobe generation for a byte/half/word store
module store_unit_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [63:0] d64,
    output logic [7:0]  s8,
    output logic        legal
);

    logic [3:0]  m;
    logic [31:0] dm;

    // size mask, size-masked data, then both shifted into an 8-lane (two word) window
    always_comb begin
        m = funct3 == INST_SB ? 4'b0001 :
            funct3 == INST_SH ? 4'b0011 :
            funct3 == INST_SW ? 4'b1111 : 4'b0000;
        legal = m != 4'b0000;
        dm = data & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        d64 = {32'b0, dm} << {off, 3'b000};
        s8 = {4'b0000, m} << off;
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: aligns RISC-V stores to memory lanes, splits word-crossing stores into two writes
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_funct3,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    state_t            state, state_nx;
    logic [63:0]       d64, d64_q;
    logic [7:0]        s8, s8_q;
    logic              legal;
    logic [ADDR_W-3:0] word_q, word;

    store_unit_align u_align (
        .off    (req_addr[1:0]),
        .funct3 (req_funct3),
        .data   (req_data),
        .d64    (d64),
        .s8     (s8),
        .legal  (legal)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    // capture the aligned image at acceptance so request inputs may change afterwards
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d64_q  <= '0;
            s8_q   <= '0;
            word_q <= '0;
        end else if (state == S_IDLE && req_valid) begin
            d64_q  <= d64;
            s8_q   <= s8;
            word_q <= req_addr[ADDR_W-1:2];
        end
    end

    // next-state logic; second write only when upper lanes carry strobes
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = !req_valid ? S_IDLE : legal ? S_WR0 : S_ERR;
            S_WR0:   state_nx = !mem_ack ? S_WR0 : s8_q[7:4] != 4'b0000 ? S_WR1 : S_DONE;
            S_WR1:   state_nx = mem_ack ? S_DONE : S_WR1;
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs are decoded from state and held registers, so they stay stable until ack
    always_comb begin
        req_ready = state == S_IDLE;
        mem_we    = state == S_WR0 || state == S_WR1;
        word      = state == S_WR1 ? word_q + 1'b1 : word_q;
        mem_addr  = mem_we ? {word, 2'b00} : '0;
        mem_wdata = state == S_WR0 ? d64_q[31:0] : state == S_WR1 ? d64_q[63:32] : '0;
        mem_wstrb = state == S_WR0 ? s8_q[3:0] : state == S_WR1 ? s8_q[7:4] : 4'b0000;
        done      = state == S_DONE;
        err       = state == S_ERR;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load/write-back path. Takes a RISC-V store (SB/SH/SW) from the execute stage: address = ALU result, data = rs2, plus funct3.
- Aligns the data to 32-bit memory lanes and generates byte strobes.
- Splits misaligned stores that cross a word boundary into two word transactions.
- Drives the data memory through a hold-until-ack request interface.

Parameters:
- ADDR_W, 32, byte-address width; mem_addr is always word-aligned (bits [1:0] = 0).
- DATA_W, 32, data/word width; only 32 is supported, giving a 4-bit strobe.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  reset, asynchronous, active-low
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request
- req_addr  input  ADDR_W  byte address of the store
- req_data  input  32  rs2 value; low bytes are used for SB/SH
- req_funct3  input  3  000=SB, 001=SH, 010=SW, others illegal
- mem_we  output  1  memory write request, held until acknowledged
- mem_addr  output  ADDR_W  word-aligned write address
- mem_wdata  output  32  lane-aligned write data
- mem_wstrb  output  4  byte-enable mask; bit i enables byte lane i
- mem_ack  input  1  memory accepted the current write (sampled on the rising edge)
- done  output  1  one-cycle pulse: store fully committed
- err  output  1  one-cycle pulse: illegal funct3, nothing written

Behaviour:
- Clock and reset: one clock domain, clk. rstn is asynchronous, active-low.
- Reset values:
  - state = IDLE, req_ready = 1
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wstrb = 0
  - done = 0, err = 0
- States: IDLE, WR0, WR1, DONE, ERR.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, the request is captured into registers at the clock edge.
  - Legal funct3 -> WR0. Illegal funct3 -> ERR.
- Alignment arithmetic:
  - off = req_addr[1:0]; size mask m = 0001 (SB), 0011 (SH), 1111 (SW).
  - 64-bit shifted data: d64 = {32'b0, data_masked} << (8*off). data_masked zeroes the bytes above the access size.
  - 8-bit strobe: s8 = {4'b0, m} << off.
  - Word 0: addr = {req_addr[ADDR_W-1:2], 2'b00}, data = d64[31:0], strobe = s8[3:0].
  - Word 1: addr = word0 addr + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000); data = d64[63:32], strobe = s8[7:4].
- WR0:
  - mem_we = 1; mem_addr, mem_wdata and mem_wstrb show word 0 and are stable until ack.
  - On mem_ack: go to WR1 if s8[7:4] != 0, otherwise go to DONE.
- WR1:
  - Same as WR0 but for word 1.
  - On mem_ack -> DONE.
- DONE:
  - done = 1 and mem_we = 0 for exactly one cycle, then IDLE.
- ERR:
  - err = 1 and mem_we = 0 for exactly one cycle, then IDLE. No memory access is made.
- req_ready = 1 only in IDLE; no request is accepted in any other state.
- Latency with zero-wait memory (ack high in the first request cycle):
  - Aligned store: accept edge t0, WR0 in cycle t1, done in t2, ready again in t3.
  - Split store: one extra cycle.
  - Each cycle mem_ack stays low adds one cycle.
- mem_ack in IDLE, DONE or ERR is ignored.
- Stability: mem_addr, mem_wdata and mem_wstrb must not change while mem_we = 1 and mem_ack = 0. Request inputs may change freely after acceptance.
- Reset mid-operation: mem_we drops to 0 immediately (asynchronous). The partial transaction is abandoned; word 0 may already be written and no rollback is required. State returns to IDLE.
- Strobe bits for lanes outside the access size are always 0; the corresponding mem_wdata bytes are 0.

Decomposition:
- Shared header (riscv_defs):
  - funct3 constants INST_SB = 3'b000, INST_SH = 3'b001, INST_SW = 3'b010, alongside the existing load constants.
  - State encoding localparams for this FSM.
- Sub-module store_align, purely combinational:
  - Inputs: addr[1:0], funct3, data.
  - Outputs: d64, s8, legal flag.
  - Reusable by a future misaligned-load splitter.

Test Plan:
- SW addr 0x00000100, data 0xDEADBEEF, ack immediate -> one write: addr 0x100, wdata 0xDEADBEEF, wstrb 1111; done in cycle t2.
- SB addr 0x00000203, data 0x12345678 -> one write: addr 0x200, wdata 0x78000000, wstrb 1000; no WR1.
- SH addr 0x00000303, data 0x0000ABCD -> two writes:
  - first: addr 0x300, wdata 0xCD000000, wstrb 1000;
  - second: addr 0x304, wdata 0x000000AB, wstrb 0001;
  - then done.
- SW addr 0xFFFFFFFE, data 0x11223344, ack delayed 3 cycles per write -> outputs held stable while waiting;
  - first: addr 0xFFFFFFFC, wdata 0x33440000, wstrb 1100;
  - second: addr 0x00000000, wdata 0x00001122, wstrb 0011;
  - done exactly once.
- funct3 = 011 -> err pulses one cycle, mem_we never asserts, req_ready returns to 1 two cycles after acceptance.
- rstn low during WR1 of a split SW -> mem_we = 0 and req_ready = 1 immediately; after release, a new SB is accepted and completes normally.
